// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
// Shared definitions for the memory controller slice: bus widths, the
// default RAM base address and the controller state encoding.
// Imported by mem_decode and mem_ctrl.
package mem_ctrl_pkg;

  localparam int ADDR_W = 16;
  localparam int OFFS_W = 15;
  localparam int DATA_W = 8;

  // RAM occupies the upper 32 KiB of the 16-bit byte address space.
  localparam logic [ADDR_W-1:0] RAM_BASE_DEFAULT = 16'h8000;

  // Explicit values keep the encoding stable for anything that probes
  // the raw state bits.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_decode.sv
// mem_decode
// Combinational address decode for the memory controller.
// Ports:
//   addr   in  16 : byte address from the core
//   is_ram out  1 : address lies in the RAM region (addr >= RAM_BASE)
//   offset out 15 : byte offset inside the selected 32 KiB region
import mem_ctrl_pkg::*;

module mem_decode #(
  parameter logic [ADDR_W-1:0] RAM_BASE = RAM_BASE_DEFAULT
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              is_ram,
  output logic [OFFS_W-1:0] offset
);

  // Both regions are 32 KiB aligned, so the offset is simply the low
  // 15 bits and no subtraction or wrap handling is required.
  assign is_ram = (addr >= RAM_BASE);
  assign offset = addr[OFFS_W-1:0];

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl
// Request/response controller in front of the ramblock array and the ROM.
// Accepts single-byte loads/stores over a valid/ready handshake, steers
// them to RAM (upper half) or ROM (lower half) and returns data or a fault.
// Ports:
//   clk, rst                      : clock, async active-high reset
//   req_valid/req_ready           : request handshake
//   req_wr, req_addr, req_wdata   : request fields (1 = store)
//   rsp_valid/rsp_ready           : response handshake
//   rsp_rdata, rsp_fault          : load data (0 for stores), ROM-store fault
//   ram_address, ram_wr, ram_din  : ramblock write/address pins
//   ram_dout                      : ramblock combinational read data
//   rom_address, rom_dout         : ROM address and combinational data
// Build option: define MEMCTL_POSTED_WRITE_EN to post RAM stores, i.e. skip
// the WRITE state and pulse ram_wr during the first RESP cycle instead.
import mem_ctrl_pkg::*;

module mem_ctrl #(
  parameter logic [ADDR_W-1:0] RAM_BASE = RAM_BASE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_fault,
  output logic [OFFS_W-1:0] ram_address,
  output logic              ram_wr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [OFFS_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_dout
);

  state_t              state;
  logic [OFFS_W-1:0]   offs_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                is_ram_q;
  logic                fault_q;
  logic                req_is_ram;
  logic [OFFS_W-1:0]   req_offs;
`ifdef MEMCTL_POSTED_WRITE_EN
  logic                drain;
`endif

  mem_decode #(.RAM_BASE(RAM_BASE)) u_decode (
    .addr   (req_addr),
    .is_ram (req_is_ram),
    .offset (req_offs)
  );

  // Request capture, read-data capture and sequencing. Only one request is
  // ever in flight; everything the outputs need is latched on accept so the
  // core may change its request inputs freely afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      offs_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      is_ram_q <= 1'b0;
      fault_q  <= 1'b0;
`ifdef MEMCTL_POSTED_WRITE_EN
      drain    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            offs_q   <= req_offs;
            wdata_q  <= req_wdata;
            is_ram_q <= req_is_ram;
            fault_q  <= req_wr && !req_is_ram;
            rdata_q  <= '0;
            if (!req_wr) begin
              state <= READ;
            end else if (!req_is_ram) begin
              state <= RESP;
            end else begin
`ifdef MEMCTL_POSTED_WRITE_EN
              state <= RESP;
              drain <= 1'b1;
`else
              state <= WRITE;
`endif
            end
          end
        end
        READ: begin
          rdata_q <= is_ram_q ? ram_dout : rom_dout;
          state   <= RESP;
        end
        WRITE: begin
          state <= RESP;
        end
        RESP: begin
`ifdef MEMCTL_POSTED_WRITE_EN
          // The posted write occupies only the first RESP cycle.
          drain <= 1'b0;
`endif
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // All outputs come from registered state so ram_wr cannot glitch on
  // request-side input changes.
  assign req_ready   = (state == IDLE);
  assign rsp_valid   = (state == RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_fault   = fault_q;
  assign ram_address = offs_q;
  assign rom_address = offs_q;
  assign ram_din     = wdata_q;
`ifdef MEMCTL_POSTED_WRITE_EN
  assign ram_wr      = (state == RESP) && drain;
`else
  assign ram_wr      = (state == WRITE);
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl
// Self-checking bench for mem_ctrl. Provides a ramblock/ROM environment,
// a transaction-level reference model and a per-cycle compare process,
// plus directed literal checks and a randomized transaction phase.
module tb_mem_ctrl;

`ifdef MEMCTL_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_rdata;
  logic        rsp_fault;
  logic [14:0] ram_address;
  logic        ram_wr;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [14:0] rom_address;
  logic [7:0]  rom_dout;

  int vectors = 0;
  int miscompares = 0;

  mem_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .ram_address(ram_address), .ram_wr(ram_wr), .ram_din(ram_din),
    .ram_dout(ram_dout), .rom_address(rom_address), .rom_dout(rom_dout)
  );

  always #5 clk = ~clk;

  // ROM contents are a fixed function of the address.
  function automatic logic [7:0] romValue(input logic [14:0] a);
    return a[7:0] ^ 8'hB5;
  endfunction

  // Environment: plain synchronous-write, asynchronous-read RAM and ROM.
  logic [7:0] ram [0:32767];
  bit env_cleared = 1'b0;
  always @(posedge clk) begin
    if (!env_cleared) begin
      for (int i = 0; i < 32768; i++) ram[i] = 8'h00;
      env_cleared = 1'b1;
    end else if (ram_wr) begin
      ram[ram_address] = ram_din;
    end
  end
  assign ram_dout = ram[ram_address];
  assign rom_dout = romValue(rom_address);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: one outstanding transaction described by when it was
  // accepted, when its response must appear and what it must carry.
  // Interval k is the clock period following rising edge k.
  logic [7:0] exp_ram [0:32767];
  bit         m_cleared = 1'b0;
  int         cyc = 0;
  bit         m_busy = 1'b0;
  int         m_acc = 0;
  int         m_rsp = 0;
  bit         m_ramst = 1'b0;
  bit         m_wr = 1'b0;
  bit         m_fault = 1'b0;
  logic [14:0] m_off = '0;
  logic [7:0]  m_data = '0;
  logic [7:0]  m_rdata = '0;

  always @(posedge clk or posedge rst) begin
    if (!m_cleared) begin
      for (int i = 0; i < 32768; i++) exp_ram[i] = 8'h00;
      m_cleared = 1'b1;
    end
    if (rst) begin
      m_busy = 1'b0;
    end else if (m_busy) begin
      if (m_ramst && cyc == m_acc) exp_ram[m_off] = m_data;
      if (cyc >= m_rsp && rsp_ready) m_busy = 1'b0;
    end else if (req_valid) begin
      m_busy  = 1'b1;
      m_acc   = cyc + 1;
      m_wr    = req_wr;
      m_off   = req_addr[14:0];
      m_data  = req_wdata;
      m_ramst = req_wr && (req_addr >= 16'h8000);
      m_fault = req_wr && (req_addr < 16'h8000);
      if (req_wr) m_rdata = 8'h00;
      else if (req_addr >= 16'h8000) m_rdata = exp_ram[req_addr[14:0]];
      else m_rdata = romValue(req_addr[14:0]);
      m_rsp = m_acc + ((m_fault || (m_ramst && POSTED)) ? 0 : 1);
    end
    cyc++;
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("rst_req_ready", req_ready, 1);
      checkOutput("rst_rsp_valid", rsp_valid, 0);
      checkOutput("rst_ram_wr", ram_wr, 0);
      checkOutput("rst_rsp_rdata", rsp_rdata, 0);
      checkOutput("rst_rsp_fault", rsp_fault, 0);
      checkOutput("rst_ram_address", ram_address, 0);
      checkOutput("rst_ram_din", ram_din, 0);
      checkOutput("rst_rom_address", rom_address, 0);
    end else begin
      checkOutput("req_ready", req_ready, !m_busy);
      checkOutput("rsp_valid", rsp_valid, m_busy && cyc >= m_rsp);
      checkOutput("ram_wr", ram_wr, m_busy && m_ramst && cyc == m_acc);
      if (m_busy && cyc >= m_rsp) begin
        checkOutput("rsp_rdata", rsp_rdata, m_rdata);
        checkOutput("rsp_fault", rsp_fault, m_fault);
      end
      if (m_busy && m_ramst && cyc == m_acc) begin
        checkOutput("wr_address", ram_address, m_off);
        checkOutput("wr_din", ram_din, m_data);
      end
      if (m_busy && !m_wr && cyc == m_acc) begin
        checkOutput("rd_ram_address", ram_address, m_off);
        checkOutput("rd_rom_address", rom_address, m_off);
      end
    end
  end

  // Runs one transaction; called and returns at a falling edge.
  task automatic applyStimulus(input logic wr, input logic [15:0] addr, input logic [7:0] data,
                               input int hold, input logic early,
                               output logic [7:0] rdata, output logic fault, output int lat);
    int k;
    k = 0;
    while (!req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) checkOutput("ready_timeout", 0, 1);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = data;
    rsp_ready = early;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_wr    = 1'($urandom);
    req_addr  = 16'($urandom);
    req_wdata = 8'($urandom);
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    rdata = rsp_rdata;
    fault = rsp_fault;
    if (lat >= 50) begin
      checkOutput("rsp_timeout", 0, 1);
      rsp_ready = 1'b0;
    end else if (early) begin
      @(negedge clk);
      rsp_ready = 1'b0;
    end else begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        checkOutput("hold_rdata", rsp_rdata, rdata);
        checkOutput("hold_valid", rsp_valid, 1);
        checkOutput("hold_req_ready", req_ready, 0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] rd;
    logic       flt;
    int         lat;
    int         errs;
    logic [14:0] pool [0:5];
    pool[0] = 15'h1234; pool[1] = 15'h0010; pool[2] = 15'h7FFF;
    pool[3] = 15'h0000; pool[4] = 15'h4321; pool[5] = 15'h2AAA;

    repeat (2) @(negedge clk);
    checkOutput("reset_req_ready", req_ready, 1);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_ram_wr", ram_wr, 0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(1'b1, 16'h9234, 8'h12, 0, 1'b0, rd, flt, lat);
    checkOutput("st_ram_lat", lat, POSTED ? 0 : 1);
    checkOutput("st_ram_fault", flt, 0);
    checkOutput("st_ram_rdata", rd, 8'h00);
    checkOutput("st_ram_written", ram[15'h1234], 8'h12);

    applyStimulus(1'b0, 16'h9234, 8'h00, 0, 1'b0, rd, flt, lat);
    checkOutput("ld_ram_data", rd, 8'h12);
    checkOutput("ld_ram_lat", lat, 1);
    checkOutput("ld_ram_fault", flt, 0);

    applyStimulus(1'b0, 16'h0010, 8'h00, 0, 1'b0, rd, flt, lat);
    checkOutput("ld_rom_data", rd, 8'hA5);
    checkOutput("ld_rom_lat", lat, 1);

    applyStimulus(1'b0, 16'h7FFF, 8'h00, 0, 1'b1, rd, flt, lat);
    checkOutput("ld_rom_top", rd, 8'h4A);

    applyStimulus(1'b1, 16'h0010, 8'h77, 0, 1'b0, rd, flt, lat);
    checkOutput("st_rom_fault", flt, 1);
    checkOutput("st_rom_lat", lat, 0);
    checkOutput("st_rom_ram_unchanged", ram[15'h0010], 8'h00);

    applyStimulus(1'b1, 16'h8000, 8'h3C, 0, 1'b1, rd, flt, lat);
    applyStimulus(1'b0, 16'h8000, 8'h00, 0, 1'b0, rd, flt, lat);
    checkOutput("ld_ram_base", rd, 8'h3C);

    applyStimulus(1'b0, 16'h9234, 8'h00, 5, 1'b0, rd, flt, lat);
    checkOutput("hold_load_data", rd, 8'h12);
    checkOutput("ready_after_release", req_ready, 1);

    // Reset in the middle of the write cycle.
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'h9234; req_wdata = 8'h55;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("wr_before_rst", ram_wr, 1);
    #1 rst = 1'b1;
    #1;
    checkOutput("wr_cut_by_rst", ram_wr, 0);
    checkOutput("rst_mid_req_ready", req_ready, 1);
    checkOutput("rst_mid_rsp_valid", rsp_valid, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("no_rsp_after_rst", rsp_valid, 0);
    end
    checkOutput("ram_kept_after_rst", ram[15'h1234], 8'h12);

    for (int n = 0; n < 300; n++) begin
      logic [15:0] a;
      a = {1'($urandom), pool[$urandom_range(0, 5)]};
      applyStimulus(1'($urandom), a, 8'($urandom), $urandom_range(0, 3),
                    ($urandom_range(0, 3) == 0), rd, flt, lat);
    end

    repeat (3) @(negedge clk);
    errs = 0;
    for (int i = 0; i < 32768; i++) if (ram[i] !== exp_ram[i]) errs++;
    checkOutput("ram_final", errs, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Request/response memory controller directly upstream of the 32 KiB `ramblock`: it accepts single-byte load/store requests from the core over a valid/ready handshake, decodes a 16-bit address into RAM (upper half) or ROM (lower half), drives the `ramblock` address/wr/din pins, and returns read data or a fault. It owns all sequencing so `ramblock` stays a plain synchronous-write, asynchronous-read array.

## Interface
Parameters:
- `RAM_BASE`, 16'h8000, first RAM address; must be 32 KiB aligned.

Ports:
- `clk` in 1: sole clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `req_valid` in 1: core presents a request.
- `req_ready` out 1: controller can accept; transfer when both high at posedge.
- `req_wr` in 1: 1 = store, 0 = load.
- `req_addr` in 16: byte address.
- `req_wdata` in 8: store data.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: core consumes response; transfer when both high at posedge.
- `rsp_rdata` out 8: load data; 8'h00 for stores.
- `rsp_fault` out 1: store targeted ROM region.
- `ram_address` out 15: to `ramblock.address`.
- `ram_wr` out 1: to `ramblock.wr`.
- `ram_din` out 8: to `ramblock.din`.
- `ram_dout` in 8: from `ramblock.dout` (combinational read).
- `rom_address` out 15: ROM read address.
- `rom_dout` in 8: ROM data (combinational read).

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE: `req_ready`=1. On accept latch `req_wr`, `req_addr`, `req_wdata`; region = (`req_addr` >= `RAM_BASE`).
  - load → READ.
  - store to RAM → WRITE (or RESP, see Configuration).
  - store to ROM → RESP with `rsp_fault`=1, no RAM access.
- READ: `ram_address`/`rom_address` = latched addr[14:0]; at posedge capture `ram_dout` or `rom_dout` per region into `rsp_rdata`; → RESP.
- WRITE: `ram_wr`=1, `ram_address`=latched addr[14:0], `ram_din`=latched data; → RESP.
- RESP: `rsp_valid`=1, `rsp_rdata`/`rsp_fault` held stable; on `rsp_ready` → IDLE. `req_ready`=0 outside IDLE.
- `ram_wr` is high only in WRITE (or the posted-write cycle); never glitches on request inputs (driven from registered state only).
- Address wrap: offset is addr[14:0] for both regions; no wrap arithmetic needed.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=8'h00, `rsp_fault`=0, `ram_wr`=0, `ram_address`=0, `ram_din`=0, `rom_address`=0.
- Load: accept at edge N, READ cycle N+1, `rsp_valid` from N+2.
- Store (non-posted): accept N, `ram_wr` cycle N+1, `rsp_valid` from N+2.
- ROM store fault: accept N, `rsp_valid`+`rsp_fault` from N+1.
- Back-to-back: response consumed at edge M → `req_ready` in cycle M+1; one request in flight max.
- `rsp_ready` held high early: no effect until RESP.
- `rst` mid-operation: outputs return to reset values immediately (asynchronously); an in-flight `ram_wr` pulse is truncated and its write is not guaranteed; pending response is dropped.

## Configuration
- `MEMCTL_POSTED_WRITE_EN` defined: RAM store skips WRITE; state goes IDLE→RESP and `ram_wr` pulses during the first RESP cycle only (tracked by a one-bit drain flag), so `rsp_valid` rises at N+1. The RAM update is still complete before any following request can be accepted.
- Undefined: WRITE state used as described; `rsp_valid` at N+2.

## Structure
- Package `mem_ctrl_pkg`: state enum (IDLE, READ, WRITE, RESP), `RAM_BASE` default, address/data width constants (16, 15, 8).
- One sub-module: `mem_decode` — combinational region select and 15-bit offset from a 16-bit address.

## Test plan
- Reset: assert `rst` → `req_ready`=1, `rsp_valid`=0, `ram_wr`=0, `rsp_rdata`=8'h00.
- Store 8'h12 to 16'h9234 → `ram_wr` single cycle with `ram_address`=15'h1234, `ram_din`=8'h12; `rsp_valid` at N+2 (N+1 with `MEMCTL_POSTED_WRITE_EN`), `rsp_fault`=0.
- Load 16'h9234 after that store → `rsp_rdata`=8'h12 at N+2; load 16'h0010 with ROM model 8'hA5 → `rsp_rdata`=8'hA5, `ram_wr` never high.
- Store to 16'h0010 → `rsp_fault`=1 at N+1, no `ram_wr` pulse, RAM contents unchanged.
- Hold `rsp_ready`=0 for 5 cycles → `rsp_valid`, `rsp_rdata` stable, `req_ready`=0; release → `req_ready`=1 next cycle.
- Assert `rst` during WRITE → `ram_wr` falls immediately, state IDLE, no response issued after release.
